// File: rtl/tych_ing_arb.sv
// tych_ing_arb
//   Frame-granular round-robin arbiter. Several ingress requesters share one
//   output beat stream; a requester keeps the stream from its SOP beat until
//   its EOP beat is accepted, and every output beat carries its source port.
//   Beats that arrive without a preceding SOP (orphans) are flushed while
//   idle and counted, so downstream only ever sees well-formed frames.
//
// Ports
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/sop/eop     : per-requester beat qualifiers (N_PORTS bits)
//   in_data              : requester i at [i*DATA_W +: DATA_W]
//   in_ready             : per-requester accept (combinational)
//   out_valid/sop/eop    : registered output beat qualifiers
//   out_data, out_port   : registered payload and source port tag
//   out_ready            : downstream accept
//   busy                 : a frame grant is held
//   drop_cnt             : saturating count of flushed orphan beats
module tych_ing_arb #(
    parameter int N_PORTS = 4,
    parameter int DATA_W  = 64,
    parameter int PORT_W  = $clog2(N_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PORTS-1:0]          in_valid,
    input  logic [N_PORTS-1:0]          in_sop,
    input  logic [N_PORTS-1:0]          in_eop,
    input  logic [N_PORTS*DATA_W-1:0]   in_data,
    output logic [N_PORTS-1:0]          in_ready,
    output logic                        out_valid,
    output logic                        out_sop,
    output logic                        out_eop,
    output logic [DATA_W-1:0]           out_data,
    output logic [PORT_W-1:0]           out_port,
    input  logic                        out_ready,
    output logic                        busy,
    output logic [15:0]                 drop_cnt
);

    localparam int CNT_W = $clog2(N_PORTS + 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [PORT_W-1:0]   grant_q, grant_d;
    logic [PORT_W-1:0]   last_q, last_d;
    logic                out_valid_q, out_valid_d;
    logic                out_sop_q, out_sop_d;
    logic                out_eop_q, out_eop_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [PORT_W-1:0]   out_port_q, out_port_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;

    logic [N_PORTS-1:0]  in_ready_c;
    logic [N_PORTS-1:0]  cand;
    logic [N_PORTS-1:0]  orphan;
    logic                lock_ready;
    logic                win_found;
    logic [PORT_W-1:0]   win_idx;
    logic [CNT_W-1:0]    n_orphan;
    logic [16:0]         drop_sum;
    logic [DATA_W-1:0]   port_data [N_PORTS];

    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_unpack
        assign port_data[gi] = in_data[gi*DATA_W +: DATA_W];
    end

    assign cand       = in_valid & in_sop;
    assign orphan     = in_valid & ~in_sop;
    // The output register can take a beat if it is empty or draining now.
    assign lock_ready = ~out_valid_q | out_ready;

    // Rotating priority search: start just after the last winner and wrap.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= N_PORTS; k++) begin
            idx = (int'(last_q) + k) % N_PORTS;
            if (!win_found && cand[PORT_W'(idx)]) begin
                win_found = 1'b1;
                win_idx   = PORT_W'(idx);
            end
        end
    end

    always_comb begin
        n_orphan = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            n_orphan = n_orphan + CNT_W'(orphan[i]);
        end
    end

    assign drop_sum = {1'b0, drop_cnt_q} + 17'(n_orphan);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_data_d  = out_data_q;
        out_port_d  = out_port_q;
        drop_cnt_d  = drop_cnt_q;
        in_ready_c  = '0;

        case (state_q)
            ST_IDLE: begin
                // Orphans are accepted and discarded; SOP candidates wait
                // for the grant and are not accepted in the arbitration cycle.
                in_ready_c = orphan;
                drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
                if (out_ready) begin
                    out_valid_d = 1'b0;
                end
                if (win_found) begin
                    grant_d = win_idx;
                    last_d  = win_idx;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                in_ready_c[grant_q] = lock_ready;
                if (in_valid[grant_q] && lock_ready) begin
                    out_valid_d = 1'b1;
                    out_sop_d   = in_sop[grant_q];
                    out_eop_d   = in_eop[grant_q];
                    out_data_d  = port_data[grant_q];
                    out_port_d  = grant_q;
                    if (in_eop[grant_q]) begin
                        state_d = ST_IDLE;
                    end
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Hold every accept low while reset is asserted.
    assign in_ready = rst ? '0 : in_ready_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            last_q      <= PORT_W'(N_PORTS - 1);
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_data_q  <= '0;
            out_port_q  <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_data_q  <= out_data_d;
            out_port_q  <= out_port_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign out_data  = out_data_q;
    assign out_port  = out_port_q;
    assign busy      = (state_q == ST_LOCKED);
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_tych_ing_arb.sv
// tb_tych_ing_arb
//   Bench for tych_ing_arb (4 ports, 64-bit data). Per-port beat queues feed
//   the requesters; a frame-level reference model of the arbitration rules
//   predicts accepts and output register contents every cycle. Directed
//   scenarios add fixed-value checks on the observed output beat stream.
`timescale 1ns/1ps
module tb_tych_ing_arb;

    localparam int NP = 4;
    localparam int DW = 64;
    localparam int PW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NP-1:0]     in_valid = '0;
    logic [NP-1:0]     in_sop = '0;
    logic [NP-1:0]     in_eop = '0;
    logic [NP*DW-1:0]  in_data = '0;
    logic [NP-1:0]     in_ready;
    logic              out_valid, out_sop, out_eop;
    logic [DW-1:0]     out_data;
    logic [PW-1:0]     out_port;
    logic              out_ready = 1'b1;
    logic              busy;
    logic [15:0]       drop_cnt;

    always #5 clk = ~clk;

    tych_ing_arb #(.N_PORTS(NP), .DATA_W(DW), .PORT_W(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_data  (out_data),
        .out_port  (out_port),
        .out_ready (out_ready),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    typedef struct { logic [63:0] d; bit s; bit e; } beat_t;
    typedef struct { int cyc; int port; bit s; bit e; logic [63:0] d; } obs_t;

    beat_t     q [NP][$];
    obs_t      obs [$];
    bit [NP-1:0] en = '1;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int t0       = 0;

    logic [NP-1:0] rdy_h [64];
    logic          ov_h  [64];
    logic [63:0]   od_h  [64];

    // Reference model state: owner -1 means no frame is granted.
    int          m_owner, m_last, m_drop, m_op;
    bit          m_ov, m_os, m_oe;
    logic [63:0] m_od;
    bit [NP-1:0] m_rdy;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    task automatic m_reset();
        m_owner = -1; m_last = NP - 1; m_drop = 0; m_op = 0;
        m_ov = 0; m_os = 0; m_oe = 0; m_od = '0;
    endtask

    task automatic m_calc_ready();
        m_rdy = '0;
        if (rst) return;
        if (m_owner < 0) begin
            for (int i = 0; i < NP; i++) m_rdy[i] = in_valid[i] && !in_sop[i];
        end else begin
            m_rdy[m_owner] = !m_ov || out_ready;
        end
    endtask

    task automatic m_advance();
        int n;
        int o;
        o = m_owner;
        if (o < 0) begin
            n = 0;
            for (int i = 0; i < NP; i++) if (in_valid[i] && !in_sop[i]) n++;
            m_drop = (m_drop + n > 65535) ? 65535 : m_drop + n;
            if (out_ready) m_ov = 0;
            for (int k = 1; k <= NP; k++) begin
                int p;
                p = (m_last + k) % NP;
                if (in_valid[p] && in_sop[p]) begin
                    m_owner = p;
                    m_last  = p;
                    break;
                end
            end
        end else begin
            if (in_valid[o] && m_rdy[o]) begin
                m_ov = 1;
                m_os = in_sop[o];
                m_oe = in_eop[o];
                m_od = in_data[o*DW +: DW];
                m_op = o;
                if (in_eop[o]) m_owner = -1;
            end else if (out_ready) begin
                m_ov = 0;
            end
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            if (q[i].size() > 0 && en[i]) begin
                in_valid[i] = 1'b1;
                in_sop[i]   = q[i][0].s;
                in_eop[i]   = q[i][0].e;
                in_data[i*DW +: DW] = q[i][0].d;
            end else begin
                in_valid[i] = 1'b0;
                in_sop[i]   = 1'($urandom);
                in_eop[i]   = 1'($urandom);
                in_data[i*DW +: DW] = {$urandom, $urandom};
            end
        end
    endtask

    // One clock: drive from queues, compare at the falling edge, then
    // advance the model and pop accepted beats before the next rising edge.
    task automatic cycle();
        int rel;
        drive();
        @(negedge clk);
        if (rst) m_reset();
        m_calc_ready();
        chk("in_ready",  in_ready, m_rdy);
        chk("out_valid", out_valid, m_ov);
        chk("out_sop",   out_sop, m_os);
        chk("out_eop",   out_eop, m_oe);
        chk("out_data",  out_data, m_od);
        chk("out_port",  out_port, m_op);
        chk("busy",      busy, (m_owner >= 0));
        chk("drop_cnt",  drop_cnt, m_drop);
        rel = cyc - t0;
        if (rel >= 0 && rel < 64) begin
            rdy_h[rel] = in_ready;
            ov_h[rel]  = out_valid;
            od_h[rel]  = out_data;
        end
        if (out_valid && out_ready) begin
            obs.push_back('{cyc, int'(out_port), out_sop, out_eop, out_data});
            $display("beat cyc=%0d port=%0d sop=%0d eop=%0d data=%h",
                     cyc, out_port, out_sop, out_eop, out_data);
        end
        if (!rst) begin
            for (int i = 0; i < NP; i++)
                if (in_valid[i] && m_rdy[i]) void'(q[i].pop_front());
            m_advance();
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_queues();
        for (int i = 0; i < NP; i++) q[i].delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        en = '1;
        clear_queues();
        run(2);
        rst = 1'b0;
        obs.delete();
        t0 = cyc;
    endtask

    task automatic add_frame(input int p, input int n, input logic [63:0] base);
        for (int k = 0; k < n; k++)
            q[p].push_back('{base + 64'(k), (k == 0), (k == n - 1)});
    endtask

    task automatic add_orphan(input int p, input logic [63:0] d);
        q[p].push_back('{d, 1'b0, 1'b0});
    endtask

    initial begin
        int exp_p [6];
        m_reset();
        @(posedge clk);
        #1;

        // Single port, 3-beat frame on port 2.
        do_reset();
        add_frame(2, 3, 64'hA1);
        run(8);
        chk("t1_ready_sop_cycle", rdy_h[0][2], 1'b0);
        chk("t1_ready_after",     rdy_h[1][2], 1'b1);
        chk("t1_count", obs.size(), 3);
        for (int k = 0; k < 3 && k < obs.size(); k++) begin
            chk("t1_data", obs[k].d, 64'hA1 + 64'(k));
            chk("t1_port", obs[k].port, 2);
            chk("t1_time", obs[k].cyc - t0, 2 + k);
        end
        chk("t1_busy_end", busy, 1'b0);

        // Round robin over ports 0, 1, 3 with 2-beat frames.
        do_reset();
        for (int f = 0; f < 2; f++) begin
            add_frame(0, 2, 64'h0000 + 64'(f * 16));
            add_frame(1, 2, 64'h1000 + 64'(f * 16));
            add_frame(3, 2, 64'h3000 + 64'(f * 16));
        end
        run(30);
        exp_p = '{0, 1, 3, 0, 1, 3};
        chk("t2_count", obs.size(), 12);
        for (int k = 0; k < 12 && k < obs.size(); k++) begin
            chk("t2_port", obs[k].port, exp_p[k/2]);
            chk("t2_sop", obs[k].s, (k % 2) == 0);
            if (k > 0) chk("t2_gap", obs[k].cyc - obs[k-1].cyc, (k % 2) ? 1 : 2);
        end

        // Backpressure: out_ready low for 5 cycles once beat 2 is shown.
        do_reset();
        add_frame(0, 4, 64'hB1);
        for (int i = 0; i < 16; i++) begin
            out_ready = !(i >= 3 && i <= 7);
            cycle();
        end
        out_ready = 1'b1;
        for (int i = 3; i <= 7; i++) begin
            chk("t3_hold_data", od_h[i], 64'hB2);
            chk("t3_hold_valid", ov_h[i], 1'b1);
            chk("t3_stall_ready", rdy_h[i][0], 1'b0);
        end
        chk("t3_count", obs.size(), 4);
        for (int k = 0; k < 4 && k < obs.size(); k++)
            chk("t3_data", obs[k].d, 64'hB1 + 64'(k));

        // Orphan flush next to a real frame.
        do_reset();
        for (int k = 0; k < 3; k++) add_orphan(1, 64'hDEAD0 + 64'(k));
        add_frame(0, 2, 64'hC1);
        run(10);
        chk("t4_drop", drop_cnt, 16'd3);
        chk("t4_count", obs.size(), 2);
        for (int k = 0; k < 2 && k < obs.size(); k++) begin
            chk("t4_port", obs[k].port, 0);
            chk("t4_data", obs[k].d, 64'hC1 + 64'(k));
        end

        // Saturate drop_cnt with 65540 orphans, then single-beat frames.
        do_reset();
        for (int i = 0; i < NP; i++)
            for (int k = 0; k < 16385; k++) add_orphan(i, 64'(k));
        run(16385);
        chk("t5_drop_sat", drop_cnt, 16'hFFFF);
        obs.delete();
        add_frame(0, 1, 64'hE0);
        add_frame(1, 1, 64'hE1);
        run(8);
        chk("t5_count", obs.size(), 2);
        for (int k = 0; k < 2 && k < obs.size(); k++) begin
            chk("t5_port", obs[k].port, k);
            chk("t5_sop", obs[k].s, 1'b1);
            chk("t5_eop", obs[k].e, 1'b1);
        end
        if (obs.size() >= 2) chk("t5_spacing", obs[1].cyc - obs[0].cyc, 2);
        chk("t5_drop_hold", drop_cnt, 16'hFFFF);

        // Reset in the middle of a 5-beat frame on port 3.
        do_reset();
        add_frame(3, 5, 64'hF1);
        run(4);
        chk("t6_pre_count", obs.size(), 2);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", out_valid, 1'b0);
        chk("t6_rst_data",  out_data, 64'h0);
        chk("t6_rst_port",  out_port, 0);
        chk("t6_rst_sop",   out_sop, 1'b0);
        chk("t6_rst_busy",  busy, 1'b0);
        chk("t6_rst_ready", in_ready, 4'h0);
        cycle();
        clear_queues();
        cycle();
        rst = 1'b0;
        obs.delete();
        add_frame(3, 2, 64'h3F0);
        add_frame(0, 2, 64'h0F0);
        run(10);
        chk("t6_count", obs.size(), 4);
        if (obs.size() >= 4) begin
            chk("t6_first_port",  obs[0].port, 0);
            chk("t6_second_port", obs[2].port, 3);
        end

        // Randomised traffic against the model.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            for (int p = 0; p < NP; p++) begin
                en[p] = ($urandom_range(0, 4) != 0);
                if (q[p].size() == 0 && $urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 6) == 0)
                        q[p].push_back('{{$urandom, $urandom}, 1'b0, 1'($urandom)});
                    else
                        add_frame(p, int'($urandom_range(1, 4)), {$urandom, $urandom});
                end
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
